// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D round-robin scheduler: FSM states,
// rotation index encodings and the SPI command word builder.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD1,
    WAIT1,
    GAP,
    CMD2,
    WAIT2,
    UPDATE
  } state_t;

  localparam logic [1:0] IDX_LFT   = 2'd0;
  localparam logic [1:0] IDX_RGHT  = 2'd1;
  localparam logic [1:0] IDX_STEER = 2'd2;
  localparam logic [1:0] IDX_BATT  = 2'd3;

  // ADC128S control word: channel select sits in bits [13:11], rest zero
  function automatic logic [15:0] mk_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_trig_timer.sv
// Free-running period timer that emits a 1-cycle expiry pulse every
// AUTO_PERIOD cycles. AUTO_PERIOD=0 removes the counter entirely.
module a2d_trig_timer #(
  parameter int AUTO_PERIOD = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic expire
);

  generate
    if (AUTO_PERIOD > 0) begin : g_timer
      localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      localparam logic [CW-1:0] LAST = CW'(AUTO_PERIOD - 1);

      logic [CW-1:0] cnt;

      // Count 0..AUTO_PERIOD-1 and wrap; never pauses for the scheduler
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt <= '0;
        else if (cnt == LAST)
          cnt <= '0;
        else
          cnt <= cnt + CW'(1);
      end

      assign expire = (cnt == LAST);
    end else begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk ^ rst_n;
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin conversion scheduler for the shared ADC128S A2D.
// Rotates left load cell, right load cell, steering pot and battery,
// issuing two SPI transactions per conversion (command, then readback).
// Optional build macro: A2D_FILT_EN enables a 2-tap averaging filter
// on each stored result (first capture per channel after reset is raw).
module a2d_rr_sched #(
  parameter int         AUTO_PERIOD = 0,
  parameter logic [2:0] CH_LFT      = 3'd0,
  parameter logic [2:0] CH_RGHT     = 3'd4,
  parameter logic [2:0] CH_STEER    = 3'd5,
  parameter logic [2:0] CH_BATT     = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        smpl_vld,
  output logic [1:0]  smpl_idx,
  output logic        busy
);

  import a2d_pkg::*;

  state_t      state;
  logic [1:0]  idx;
  logic [11:0] res [4];
  logic        tmr_exp;
  logic        trig;
  logic [2:0]  chnl;
  logic [11:0] cap_val;
  logic [3:0]  unused_resp_hi;

  // Upper nibble of the A2D response carries no data
  assign unused_resp_hi = resp[15:12];

  a2d_trig_timer #(
    .AUTO_PERIOD(AUTO_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .expire(tmr_exp)
  );

  assign trig = nxt | tmr_exp;

  assign lft_ld    = res[IDX_LFT];
  assign rght_ld   = res[IDX_RGHT];
  assign steer_pot = res[IDX_STEER];
  assign batt      = res[IDX_BATT];

  // Map rotation index to the physical A2D channel
  always_comb begin
    chnl = CH_LFT;
    case (idx)
      IDX_LFT:   chnl = CH_LFT;
      IDX_RGHT:  chnl = CH_RGHT;
      IDX_STEER: chnl = CH_STEER;
      IDX_BATT:  chnl = CH_BATT;
      default:   chnl = CH_LFT;
    endcase
  end

`ifdef A2D_FILT_EN
  logic [3:0]  seen;
  logic [12:0] sum;

  // Rounded average of stored and new sample; raw until the channel has data
  always_comb begin
    sum     = {1'b0, res[idx]} + {1'b0, resp[11:0]} + 13'd1;
    cap_val = seen[idx] ? sum[12:1] : resp[11:0];
  end

  // Remember which channels have received their first capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seen <= 4'b0000;
    else if (state == WAIT2 && done)
      seen[idx] <= 1'b1;
  end
`else
  // Store the raw 12-bit conversion result
  always_comb begin
    cap_val = resp[11:0];
  end
`endif

  // Conversion sequencer with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= IDX_LFT;
      wrt      <= 1'b0;
      cmd      <= 16'h0000;
      smpl_vld <= 1'b0;
      smpl_idx <= 2'd0;
      busy     <= 1'b0;
      for (int i = 0; i < 4; i++)
        res[i] <= 12'h000;
    end else begin
      wrt      <= 1'b0;
      smpl_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            cmd   <= mk_cmd(chnl);
            wrt   <= 1'b1;
            busy  <= 1'b1;
            state <= CMD1;
          end
        end
        CMD1:  state <= WAIT1;
        WAIT1: if (done) state <= GAP;
        GAP: begin
          wrt   <= 1'b1;
          state <= CMD2;
        end
        CMD2:  state <= WAIT2;
        WAIT2: begin
          if (done) begin
            res[idx] <= cap_val;
            smpl_vld <= 1'b1;
            smpl_idx <= idx;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          idx   <= idx + 2'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Self-checking bench for a2d_rr_sched: a nxt-driven instance exercised
// with directed conversion vectors and corner sequences, plus a second
// instance with AUTO_PERIOD=200 to observe self-triggered scheduling.
module tb_a2d_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        done = 1'b0;
  logic [15:0] resp = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        smpl_vld;
  logic [1:0]  smpl_idx;
  logic        busy;

  logic        nxt_t = 1'b0;
  logic        done_t = 1'b0;
  logic [15:0] resp_t = 16'h0123;
  logic        wrt_t;
  logic [15:0] cmd_t;
  logic [11:0] lft_t, rght_t, steer_t, batt_t;
  logic        smpl_vld_t;
  logic [1:0]  smpl_idx_t;
  logic        busy_t;

  int cyc = 0;
  int lat = 40;
  int lat_t = 40;
  logic stray = 1'b0;
  int checks = 0;
  int fails = 0;
  int wrt_cyc[$];
  logic [15:0] wrt_cmd[$];
  int done_cyc[$];
  int starts_t[$];
  int smpl_cyc;

  typedef struct {
    logic [15:0] resp;
    logic [15:0] exp_cmd;
    logic [1:0]  exp_idx;
    logic [11:0] exp_val;
  } vec_t;

  vec_t vecs[5];

`ifdef A2D_FILT_EN
  localparam logic [11:0] EXP_LFT_SECOND = 12'h181;
  localparam logic [11:0] EXP_RGHT_DROP  = 12'h5DE;
`else
  localparam logic [11:0] EXP_LFT_SECOND = 12'h201;
  localparam logic [11:0] EXP_RGHT_DROP  = 12'h777;
`endif

  a2d_rr_sched dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .cmd(cmd),
    .done(done), .resp(resp), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .steer_pot(steer_pot), .batt(batt), .smpl_vld(smpl_vld),
    .smpl_idx(smpl_idx), .busy(busy)
  );

  a2d_rr_sched #(.AUTO_PERIOD(200)) dut_t (
    .clk(clk), .rst_n(rst_n), .nxt(nxt_t), .wrt(wrt_t), .cmd(cmd_t),
    .done(done_t), .resp(resp_t), .lft_ld(lft_t), .rght_ld(rght_t),
    .steer_pot(steer_t), .batt(batt_t), .smpl_vld(smpl_vld_t),
    .smpl_idx(smpl_idx_t), .busy(busy_t)
  );

  always #5 clk = ~clk;

  // Cycle stamp used for latency and spacing measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Mock SPI monarch for the nxt-driven instance: done pulses lat cycles after wrt
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      done = stray;
      if (!rst_n) begin
        cnt = 0;
      end else if (wrt) begin
        cnt = lat;
        wrt_cyc.push_back(cyc);
        wrt_cmd.push_back(cmd);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  // Mock SPI monarch for the timer instance; records the cycle of each conversion start
  initial begin
    int cnt, wcnt;
    cnt = 0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      done_t = 1'b0;
      if (!rst_n) begin
        cnt = 0;
        wcnt = 0;
      end else if (wrt_t) begin
        cnt = lat_t;
        if (wcnt % 2 == 0) starts_t.push_back(cyc);
        wcnt++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) done_t = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] regByIdx(input logic [1:0] i);
    case (i)
      2'd0: return lft_ld;
      2'd1: return rght_ld;
      2'd2: return steer_pot;
      default: return batt;
    endcase
  endfunction

  task automatic clearLogs();
    wrt_cyc.delete();
    wrt_cmd.delete();
    done_cyc.delete();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    starts_t.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulse nxt for one cycle; returns at the negedge of the cycle after the trigger
  task automatic applyStimulus(input logic [15:0] r);
    resp = r;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic waitSample(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (smpl_vld) begin
        ok = 1'b1;
        break;
      end
    end
    smpl_cyc = cyc;
    if (!ok) checkOutput("smpl_vld timeout", 32'd0, 32'd1);
  endtask

  task automatic runConversion(input vec_t v);
    bit ok;
    clearLogs();
    applyStimulus(v.resp);
    checkOutput("wrt latency", {31'd0, wrt}, 32'd1);
    checkOutput("busy on start", {31'd0, busy}, 32'd1);
    waitSample(ok);
    if (ok) begin
      checkOutput("smpl_idx", {30'd0, smpl_idx}, {30'd0, v.exp_idx});
      checkOutput("result reg", {20'd0, regByIdx(v.exp_idx)}, {20'd0, v.exp_val});
      checkOutput("wrt count", wrt_cyc.size(), 32'd2);
      if (wrt_cyc.size() == 2 && done_cyc.size() == 2) begin
        checkOutput("cmd first", {16'd0, wrt_cmd[0]}, {16'd0, v.exp_cmd});
        checkOutput("cmd second", {16'd0, wrt_cmd[1]}, {16'd0, v.exp_cmd});
        checkOutput("gap cycle", wrt_cyc[1] - done_cyc[0], 32'd2);
        checkOutput("update latency", smpl_cyc - done_cyc[1], 32'd1);
      end
      @(negedge clk);
      checkOutput("smpl_vld pulse", {31'd0, smpl_vld}, 32'd0);
      checkOutput("busy cleared", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    bit ok;

    vecs[0] = '{16'hA100, 16'h0000, 2'd0, 12'h100};
    vecs[1] = '{16'h0444, 16'h2000, 2'd1, 12'h444};
    vecs[2] = '{16'h5555, 16'h2800, 2'd2, 12'h555};
    vecs[3] = '{16'h0666, 16'h3000, 2'd3, 12'h666};
    vecs[4] = '{16'h0201, 16'h0000, 2'd0, EXP_LFT_SECOND};

    // Reset state
    doReset();
    checkOutput("reset wrt", {31'd0, wrt}, 32'd0);
    checkOutput("reset cmd", {16'd0, cmd}, 32'd0);
    checkOutput("reset regs", {lft_ld, rght_ld, steer_pot[7:0]}, 32'd0);
    checkOutput("reset regs hi", {steer_pot[11:8], batt}, 32'd0);
    checkOutput("reset smpl", {29'd0, smpl_vld, smpl_idx}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);

    // First conversion, upper response nibble discarded
    runConversion('{16'hF123, 16'h0000, 2'd0, 12'h123});

    // Full rotation from reset with index wrap
    doReset();
    for (int i = 0; i < 5; i++) runConversion(vecs[i]);
    checkOutput("rght hold", {20'd0, rght_ld}, 32'h444);
    checkOutput("steer hold", {20'd0, steer_pot}, 32'h555);
    checkOutput("batt hold", {20'd0, batt}, 32'h666);

    // Triggers during WAIT1 and during UPDATE are dropped
    clearLogs();
    applyStimulus(16'h0777);
    repeat (5) @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    waitSample(ok);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("drop wrt count", wrt_cyc.size(), 32'd2);
    checkOutput("drop busy", {31'd0, busy}, 32'd0);
    checkOutput("drop rght", {20'd0, rght_ld}, {20'd0, EXP_RGHT_DROP});

    // done while idle has no effect
    clearLogs();
    @(posedge clk);
    #1 stray = 1'b1;
    @(posedge clk);
    #1 stray = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stray busy", {31'd0, busy}, 32'd0);
    checkOutput("stray wrt", wrt_cyc.size(), 32'd0);

    // Asynchronous reset during WAIT2
    clearLogs();
    applyStimulus(16'h0999);
    for (int i = 0; i < 200 && wrt_cyc.size() < 2; i++) @(negedge clk);
    checkOutput("reach WAIT2", wrt_cyc.size(), 32'd2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async busy", {31'd0, busy}, 32'd0);
    checkOutput("async cmd", {15'd0, wrt, cmd}, 32'd0);
    checkOutput("async regs", {lft_ld, rght_ld, steer_pot[7:0]}, 32'd0);
    checkOutput("async regs hi", {steer_pot[11:8], batt}, 32'd0);
    checkOutput("async smpl", {29'd0, smpl_vld, smpl_idx}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runConversion('{16'h0ABC, 16'h0000, 2'd0, 12'hABC});

    // Timer instance, short monarch latency: one start per period
    lat_t = 40;
    doReset();
    repeat (1100) @(negedge clk);
    checkOutput("timer starts fast", {31'd0, (starts_t.size() >= 3)}, 32'd1);
    if (starts_t.size() >= 3) begin
      checkOutput("timer spacing a", starts_t[1] - starts_t[0], 32'd200);
      checkOutput("timer spacing b", starts_t[2] - starts_t[1], 32'd200);
    end

    // Timer instance, long monarch latency: every other expiry dropped
    lat_t = 150;
    doReset();
    repeat (1700) @(negedge clk);
    checkOutput("timer starts slow", {31'd0, (starts_t.size() >= 3)}, 32'd1);
    if (starts_t.size() >= 3) begin
      checkOutput("timer drop spacing a", starts_t[1] - starts_t[0], 32'd400);
      checkOutput("timer drop spacing b", starts_t[2] - starts_t[1], 32'd400);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
